umem_dual_port: RTL and testbench
=================================

# umem_dual_port

Shared unified memory for the multicore data path. It sits directly downstream of each core's `dmem_hierarchy` and serves that block's line-level requests: `u_addr`, `u_re`, `u_we`, `d_line` as write data, and `u_rd_data`/`u_rdy` as the response. Two such requesters (core 0, core 1) share one 64-bit-line array. Access is serialized through round-robin arbitration with a fixed multi-cycle latency and a one-cycle `rdy` pulse per completed transaction.

## Interface
- `LATENCY`, 4: cycles from the request being sampled to the `rdy` pulse; legal range ≥1.
- `ADDR_W`, 11: line address width; the array depth is 2**ADDR_W lines of 64 bits.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `c0_addr`  in  ADDR_W  core 0 line address.
- `c0_re`  in  1  core 0 read request, level, held until `c0_rdy`.
- `c0_we`  in  1  core 0 write request, level, held until `c0_rdy`.
- `c0_wdata`  in  64  core 0 write line (evicted Dcache line).
- `c0_rd_data`  out  64  core 0 read line.
- `c0_rdy`  out  1  core 0 transaction complete, one-cycle pulse.
- `c1_addr`, `c1_re`, `c1_we`, `c1_wdata`, `c1_rd_data`, `c1_rdy`: identical meaning for core 1.

## Operation
- A port requests when `re|we` is high. If both are high, the transaction is a write and `re` is ignored.
- The FSM has two states: IDLE and ACCESS.
  - IDLE:
    - With no request, stay in IDLE.
    - With a request, grant exactly one port.
    - On grant, latch requester id, op, addr and wdata. Load `cnt` = LATENCY-1. Go to ACCESS.
  - ACCESS:
    - Port inputs are ignored; latched values are used.
    - While `cnt`≠0, decrement `cnt`.
    - When `cnt`==0:
      - Pulse `rdy` of the latched requester.
      - For a read, drive its `rd_data` from array[latched addr].
      - For a write, update the array at that clock edge.
      - Return to IDLE.
- Arbitration:
  - A 1-bit priority pointer `prio` resets to 0.
  - If only one port requests, that port is granted.
  - If both request, the port equal to `prio` is granted.
  - After every grant, `prio` is set to the other port. This prevents starvation.
- The ungranted port keeps its request asserted and is served in a later IDLE cycle.
- `cx_rd_data` is registered. It holds its last read value until that port's next read completes. Write completions do not change it.
- If a requester drops its request during ACCESS, the transaction still completes and `rdy` still pulses.
- The array is not reset and its initial contents are don't-care.
  - Benches must write before reading.
  - Simulation may preload the array from a hex file.

## Timing
- Reset values: `c0_rdy`=`c1_rdy`=0, `c0_rd_data`=`c1_rd_data`=0, state IDLE, `prio`=0, `cnt`=0.
- A request sampled in IDLE at cycle T produces `rdy` and valid `rd_data` in cycle T+LATENCY.
- For a write in that cycle, the array holds the new value from T+LATENCY+1 onward.
- Back-to-back transactions:
  - The cycle after `rdy` is IDLE and may sample a new request. Worst-case throughput is one transaction per LATENCY+1 cycles.
  - The requester's pattern of dropping the request the cycle after `rdy`, then re-asserting it the following cycle, must work. This covers both the evict-then-fill sequence and a new miss.
- Read data is stable while `rdy` is high, so the requester may capture it with `d_we = u_rdy`.
- `rdy` is never high on both ports in the same cycle. It is never high for more than one consecutive cycle per transaction.
- Reset mid-ACCESS:
  - The transaction is aborted: no `rdy` pulse and no array write.
  - Outputs go to reset values immediately.
  - The array keeps its prior contents.
- Addresses are used as given, with no wrap or masking beyond ADDR_W bits.

## Test plan
- **Write then read:** LATENCY=4. Core 0 writes addr 0x005 with 64'h0123_4567_89AB_CDEF, then reads 0x005.
  - `c0_rdy` pulses 4 cycles after each request is sampled.
  - The read returns 64'h0123_4567_89AB_CDEF.
  - `c1_rdy` stays 0 throughout.
- **Simultaneous requests:** from reset, both cores read in the same cycle.
  - Core 0 is granted first and pulses `rdy` at T+4.
  - Core 1 is sampled at T+5 and pulses `rdy` at T+9.
  - A second simultaneous pair grants core 0 first again, because `prio` returns to 0 after core 1's grant.
- **Persistent contention:** core 0 re-requests the cycle after every `rdy` while core 1 holds its request.
  - Grants alternate 0,1,0,1.
  - Neither port waits more than one transaction.
- **Evict then fill:**
  - Core 1 writes 0x7FF with 64'hFFFF_0000_FFFF_0000. It drops `we` after `rdy` and asserts `re` to 0x010 next cycle; 0x010 was preloaded with 64'h1111.
  - Read data is 64'h1111 and a later read of 0x7FF returns the written line.
- **`re` and `we` both high:** core 0 asserts both with wdata 64'hA5A5.
  - The transaction is a write, `c0_rd_data` is unchanged, and a later read returns 64'hA5A5.
- **Reset mid-write:** `rst_n` is asserted low 2 cycles into a write to 0x020 that holds old value 64'h22.
  - `rdy` never pulses.
  - After reset, a read of 0x020 returns 64'h22.

Source files
------------

// File: rtl/umem_dual_port.sv
// Two-requester unified line memory: round-robin arbitration, fixed LATENCY
// per transaction, one-cycle rdy pulse to the granted core.
module umem_dual_port #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic              c0_re,
    input  logic              c0_we,
    input  logic [63:0]       c0_wdata,
    output logic [63:0]       c0_rd_data,
    output logic              c0_rdy,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic              c1_re,
    input  logic              c1_we,
    input  logic [63:0]       c1_wdata,
    output logic [63:0]       c1_rd_data,
    output logic              c1_rdy
);
    // state    | meaning
    // S_IDLE   | no transaction, arbitrate and sample requests
    // S_ACCESS | serving latched request, cnt counts down to completion
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               prio;
    logic               req0, req1;
    logic               grant, grant_id, finish, arrive;
    logic               arr_id, arr_we;
    logic [ADDR_W-1:0]  arr_addr;
    logic               lat_id, lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [63:0]        lat_wdata;
    logic [63:0]        mem [0:(1<<ADDR_W)-1];

    assign req0 = c0_re | c0_we;
    assign req1 = c1_re | c1_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_nxt = S_ACCESS;
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                end
            end
            S_ACCESS: begin
                if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
                else           state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // rdy and rd_data are registered, so they are loaded on the edge that
    // enters the final ACCESS cycle (cnt reaching 0).
    always_comb begin
        grant    = (state == S_IDLE) && (req0 || req1);
        grant_id = (req0 && req1) ? prio : req1;
        finish   = (state == S_ACCESS) && (cnt == '0);
        arrive   = (state_nxt == S_ACCESS) && (cnt_nxt == '0);
        arr_id   = grant ? grant_id : lat_id;
        arr_we   = grant ? (grant_id ? c1_we : c0_we) : lat_we;
        arr_addr = grant ? (grant_id ? c1_addr : c0_addr) : lat_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio       <= 1'b0;
            lat_id     <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            c0_rdy     <= 1'b0;
            c1_rdy     <= 1'b0;
            c0_rd_data <= '0;
            c1_rd_data <= '0;
        end else begin
            if (grant) begin
                prio      <= ~grant_id;
                lat_id    <= grant_id;
                lat_we    <= grant_id ? c1_we : c0_we;
                lat_addr  <= grant_id ? c1_addr : c0_addr;
                lat_wdata <= grant_id ? c1_wdata : c0_wdata;
            end
            c0_rdy <= arrive && !arr_id;
            c1_rdy <= arrive && arr_id;
            if (arrive && !arr_we && !arr_id) c0_rd_data <= mem[arr_addr];
            if (arrive && !arr_we && arr_id)  c1_rd_data <= mem[arr_addr];
        end
    end

    // Array is intentionally unreset; a reset during ACCESS clears state, so
    // the pending write never reaches it.
    always_ff @(posedge clk) begin
        if (finish && lat_we) mem[lat_addr] <= lat_wdata;
    end
endmodule

// File: tb/tb_umem_dual_port.sv
// Bench for umem_dual_port: directed scenarios plus random two-core traffic
// checked against a transaction-timeline reference model.
module tb_umem_dual_port;
    localparam int LAT = 4;
    localparam int AW  = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] c0_addr, c1_addr;
    logic          c0_re, c0_we, c1_re, c1_we;
    logic [63:0]   c0_wdata, c1_wdata, c0_rd_data, c1_rd_data;
    logic          c0_rdy, c1_rdy;

    always #5 clk = ~clk;

    umem_dual_port #(.LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_addr(c0_addr), .c0_re(c0_re), .c0_we(c0_we), .c0_wdata(c0_wdata),
        .c0_rd_data(c0_rd_data), .c0_rdy(c0_rdy),
        .c1_addr(c1_addr), .c1_re(c1_re), .c1_we(c1_we), .c1_wdata(c1_wdata),
        .c1_rd_data(c1_rd_data), .c1_rdy(c1_rdy)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // requester side
    bit            act[2], held[2], opw[2], both[2], granted[2];
    logic [AW-1:0] ad[2];
    logic [63:0]   wd[2];
    bit            rnd_on = 0, persist = 0;

    // reference model: one transaction in flight, completion at a computed edge
    logic [63:0]   ref_mem [int];
    int            edge_n = 0, free_edge = 0;
    bit            prio_m = 0, cur_busy = 0, cur_we = 0;
    int            cur_id = 0, cur_done = 0;
    logic [AW-1:0] cur_addr;
    logic [63:0]   cur_wdata;
    logic [63:0]   rd_exp[2];
    bit            rd_known[2];
    int            rdy_cyc[2], rdy_cnt[2];
    int            rdy_order[$];

    task automatic drive();
        c0_re    = act[0] && held[0] && (!opw[0] || both[0]);
        c0_we    = act[0] && held[0] && opw[0];
        c0_addr  = ad[0];
        c0_wdata = wd[0];
        c1_re    = act[1] && held[1] && (!opw[1] || both[1]);
        c1_we    = act[1] && held[1] && opw[1];
        c1_addr  = ad[1];
        c1_wdata = wd[1];
    endtask

    task automatic issue(input int p, input bit w, input bit b, input logic [AW-1:0] a,
                         input logic [63:0] d);
        act[p] = 1; held[p] = 1; opw[p] = w; both[p] = b;
        ad[p] = a; wd[p] = d; granted[p] = 0;
        drive();
    endtask

    task automatic step();
        bit rq[2];
        bit fin;
        int id, fin_id;
        bit w;
        logic [AW-1:0] a;
        @(posedge clk);
        edge_n++;
        rq[0] = c0_re || c0_we;
        rq[1] = c1_re || c1_we;
        if (rst_n && !cur_busy && edge_n >= free_edge && (rq[0] || rq[1])) begin
            if (rq[0] && rq[1]) id = int'(prio_m);
            else                id = rq[1] ? 1 : 0;
            prio_m    = (id == 0);
            cur_busy  = 1;
            cur_id    = id;
            cur_we    = opw[id];
            cur_addr  = ad[id];
            cur_wdata = wd[id];
            cur_done  = edge_n + LAT - 1;
            free_edge = edge_n + LAT + 1;
            granted[id] = 1;
        end
        @(negedge clk);
        fin = cur_busy && (cur_done == edge_n);
        fin_id = cur_id;
        chk("rdy0", 64'(c0_rdy), 64'(fin && cur_id == 0));
        chk("rdy1", 64'(c1_rdy), 64'(fin && cur_id == 1));
        if (c0_rdy) begin rdy_cyc[0] = edge_n; rdy_cnt[0]++; rdy_order.push_back(0); end
        if (c1_rdy) begin rdy_cyc[1] = edge_n; rdy_cnt[1]++; rdy_order.push_back(1); end
        if (fin) begin
            if (cur_we) ref_mem[int'(cur_addr)] = cur_wdata;
            else if (ref_mem.exists(int'(cur_addr))) begin
                rd_exp[cur_id] = ref_mem[int'(cur_addr)];
                rd_known[cur_id] = 1;
            end else rd_known[cur_id] = 0;
            act[cur_id] = 0; held[cur_id] = 0; cur_busy = 0;
        end
        if (rd_known[0]) chk("rd_data0", c0_rd_data, rd_exp[0]);
        if (rd_known[1]) chk("rd_data1", c1_rd_data, rd_exp[1]);
        for (int p = 0; p < 2; p++) begin
            if (fin && fin_id == p && persist) issue(p, 0, 0, ad[p], 64'd0);
            else if (rnd_on) begin
                if (act[p] && granted[p] && held[p] && $urandom_range(0, 7) == 0) held[p] = 0;
                else if (!act[p] && $urandom_range(0, 2) != 0) begin
                    w = 1'($urandom_range(0, 1));
                    a = ($urandom_range(0, 9) == 0) ? 11'h7FF : AW'($urandom_range(0, 15));
                    issue(p, w, w && ($urandom_range(0, 3) == 0), a, {$urandom, $urandom});
                end
            end
        end
        drive();
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((act[0] || act[1]) && n < max_cyc) begin
            step();
            n++;
        end
        chk("timeout", 64'(act[0] || act[1]), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        act = '{0, 0}; held = '{0, 0};
        drive();
        #1;
        chk("rst_rdy0", 64'(c0_rdy), 64'd0);
        chk("rst_rdy1", 64'(c1_rdy), 64'd0);
        chk("rst_rd0", c0_rd_data, 64'd0);
        chk("rst_rd1", c1_rd_data, 64'd0);
        cur_busy = 0; prio_m = 0; free_edge = 0;
        rd_exp = '{64'd0, 64'd0}; rd_known = '{1, 1};
        step();
        step();
        rst_n = 1'b1;
    endtask

    int t0, n0;

    initial begin
        act = '{0, 0}; held = '{0, 0}; opw = '{0, 0}; both = '{0, 0};
        ad = '{'0, '0}; wd = '{64'd0, 64'd0};
        rd_exp = '{64'd0, 64'd0}; rd_known = '{1, 1};
        drive();
        #3 rst_n = 1'b0;
        #1;
        chk("init_rdy0", 64'(c0_rdy), 64'd0);
        chk("init_rdy1", 64'(c1_rdy), 64'd0);
        chk("init_rd0", c0_rd_data, 64'd0);
        chk("init_rd1", c1_rd_data, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // simultaneous reads from reset, twice: core 0 first both times
        for (int k = 0; k < 2; k++) begin
            step();
            t0 = edge_n;
            issue(0, 0, 0, 11'h001, 64'd0);
            issue(1, 0, 0, 11'h002, 64'd0);
            wait_idle(40);
            chk("sim_c0_at", 64'(rdy_cyc[0]), 64'(t0 + 4));
            chk("sim_c1_at", 64'(rdy_cyc[1]), 64'(t0 + 9));
        end

        // write then read on core 0, core 1 silent
        n0 = rdy_cnt[1];
        step();
        t0 = edge_n;
        issue(0, 1, 0, 11'h005, 64'h0123_4567_89AB_CDEF);
        wait_idle(20);
        chk("wr_at", 64'(rdy_cyc[0]), 64'(t0 + 4));
        step();
        t0 = edge_n;
        issue(0, 0, 0, 11'h005, 64'd0);
        wait_idle(20);
        chk("rd_at", 64'(rdy_cyc[0]), 64'(t0 + 4));
        chk("wr_rd_data", c0_rd_data, 64'h0123_4567_89AB_CDEF);
        chk("c1_quiet", 64'(rdy_cnt[1]), 64'(n0));

        // persistent contention; prio now points at core 1 after two core-0 grants
        step();
        persist = 1;
        rdy_order.delete();
        issue(0, 0, 0, 11'h005, 64'd0);
        issue(1, 0, 0, 11'h005, 64'd0);
        for (int n = 0; n < 60 && rdy_order.size() < 4; n++) step();
        persist = 0;
        wait_idle(40);
        for (int i = 0; i < 4; i++) chk("alternate", 64'(rdy_order[i]), 64'((i % 2 == 0) ? 1 : 0));

        // evict then fill on core 1
        step();
        issue(1, 1, 0, 11'h010, 64'h1111);
        wait_idle(20);
        step();
        issue(1, 1, 0, 11'h7FF, 64'hFFFF_0000_FFFF_0000);
        wait_idle(20);
        step();
        issue(1, 0, 0, 11'h010, 64'd0);
        wait_idle(20);
        chk("fill_data", c1_rd_data, 64'h1111);
        step();
        issue(1, 0, 0, 11'h7FF, 64'd0);
        wait_idle(20);
        chk("evict_data", c1_rd_data, 64'hFFFF_0000_FFFF_0000);

        // re and we together is a write
        step();
        issue(0, 0, 0, 11'h005, 64'd0);
        wait_idle(20);
        step();
        issue(0, 1, 1, 11'h030, 64'hA5A5);
        wait_idle(20);
        chk("both_keep", c0_rd_data, 64'h0123_4567_89AB_CDEF);
        step();
        issue(0, 0, 0, 11'h030, 64'd0);
        wait_idle(20);
        chk("both_rd", c0_rd_data, 64'hA5A5);

        // reset two cycles into a write
        step();
        issue(0, 1, 0, 11'h020, 64'h22);
        wait_idle(20);
        step();
        n0 = rdy_cnt[0];
        issue(0, 1, 0, 11'h020, 64'hDEAD_BEEF);
        step();
        step();
        do_reset();
        chk("rst_no_rdy", 64'(rdy_cnt[0]), 64'(n0));
        step();
        issue(0, 0, 0, 11'h020, 64'd0);
        wait_idle(20);
        chk("rst_keep", c0_rd_data, 64'h22);

        // random traffic
        step();
        rnd_on = 1;
        repeat (3000) step();
        rnd_on = 0;
        wait_idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
